// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } uart_tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-time divider: bit_end marks the last system clock of each bit.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_framed.sv
// Configurable UART transmitter: start, 5-9 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 Tx,
  output logic                 tx_busy,
  output logic                 frame_done
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_framed: CLK_DIV must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);
  localparam bit HasParity = (PARITY != PARITY_NONE);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_end;

  assign tx_ready = (state_q == TX_IDLE) && !reset;
  assign accept   = tx_valid && tx_ready;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(accept),
    .bit_end(bit_end)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    unique case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d    = TX_START;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          // Odd parity inverts the data XOR so the total count of ones comes out odd.
          par_d      = (PARITY == PARITY_ODD) ? ~(^tx_data) : ^tx_data;
        end
      end
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxLast) begin
            bit_idx_d = '0;
            state_d   = HasParity ? TX_PARITY : TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == StopLast) begin
            state_d    = TX_IDLE;
            stop_idx_d = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level is registered, so it is derived from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    done_d = (state_q == TX_STOP) && (state_d == TX_IDLE);
  end

  assign Tx         = tx_q;
  assign tx_busy    = (state_q != TX_IDLE);
  assign frame_done = done_q;

endmodule
